// File: rtl/ttt_pkg.sv
// ttt_pkg: shared error codes, FSM state type and default board size for the move decoder
package ttt_pkg;
   localparam int N_POS_DEF = 9;
   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_RANGE = 2'd1;
   localparam logic [1:0] ERR_OCC   = 2'd2;
   typedef enum logic {ARMED = 1'b0, LOCKED = 1'b1} state_t;
endpackage

// File: rtl/onehot_decoder.sv
// onehot_decoder: combinational index -> one-hot, all-zero when in >= N
//   in  : W-bit index
//   out : N-bit one-hot (zero for out-of-range index)
module onehot_decoder #(
   parameter int N = 9,
   parameter int W = 4
) (
   input  logic [W-1:0] in,
   output logic [N-1:0] out
);
   always_comb begin
      out = '0;
      for (int i = 0; i < N; i++) out[i] = (int'(in) == i);
   end
endmodule

// File: rtl/move_decoder.sv
// move_decoder: registered move request checker, one-hot cell strobe and per-player board
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   enable, in, player  : move request level, position, player (0 = X, 1 = O)
//   clear               : synchronous new-game clear
//   out_en              : one-cycle one-hot cell write strobe
//   accept, reject, err : move result pulses and held reason code
//   board_x, board_o    : per-player occupancy; full when every cell is taken
module move_decoder
   import ttt_pkg::*;
#(
   parameter int N_POS = N_POS_DEF,
   parameter int PW    = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [PW-1:0]    in,
   input  logic             player,
   input  logic             clear,
   output logic [N_POS-1:0] out_en,
   output logic             accept,
   output logic             reject,
   output logic [1:0]       err,
   output logic [N_POS-1:0] board_x,
   output logic [N_POS-1:0] board_o,
   output logic             full
);
   state_t             state_q, state_d;
   logic               req_q, req_d, ply_q;
   logic [PW-1:0]      pos_q;
   logic [N_POS-1:0]   dec, set;
   logic               bad_range, bad_occ;
   logic [N_POS-1:0]   out_en_q, out_en_d, board_x_q, board_x_d, board_o_q, board_o_d;
   logic               accept_q, accept_d, reject_q, reject_d, full_q, full_d;
   logic [1:0]         err_q, err_d;

   // The request is captured at the sampling edge and evaluated against the
   // board one edge later, so a pending request can still be dropped by clear.
   onehot_decoder #(.N(N_POS), .W(PW)) u_dec (.in(pos_q), .out(dec));

   always_ff @(posedge clock) begin
      if (reset || clear) state_q <= ARMED;
      else                state_q <= state_d;
   end

   // LOCKED holds while enable stays high; ARMED leaves on enable.
   always_comb begin
      state_d = enable ? LOCKED : ARMED;
      req_d   = (state_q == ARMED) && enable;
   end

   always_comb begin
      bad_range = ~|dec;
      bad_occ   = |(dec & (board_x_q | board_o_q));
      accept_d  = req_q && !bad_range && !bad_occ;
      reject_d  = req_q && (bad_range || bad_occ);
      err_d     = !req_q ? err_q : bad_range ? ERR_RANGE : bad_occ ? ERR_OCC : err_q;
      set       = accept_d ? dec : '0;
      out_en_d  = set;
      board_x_d = board_x_q | (ply_q ? '0 : set);
      board_o_d = board_o_q | (ply_q ? set : '0);
      full_d    = &(board_x_d | board_o_d);
   end

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         req_q     <= 1'b0;
         pos_q     <= '0;
         ply_q     <= 1'b0;
         out_en_q  <= '0;
         accept_q  <= 1'b0;
         reject_q  <= 1'b0;
         err_q     <= ERR_NONE;
         board_x_q <= '0;
         board_o_q <= '0;
         full_q    <= 1'b0;
      end else begin
         req_q     <= req_d;
         pos_q     <= in;
         ply_q     <= player;
         out_en_q  <= out_en_d;
         accept_q  <= accept_d;
         reject_q  <= reject_d;
         err_q     <= err_d;
         board_x_q <= board_x_d;
         board_o_q <= board_o_d;
         full_q    <= full_d;
      end
   end

   assign out_en  = out_en_q;
   assign accept  = accept_q;
   assign reject  = reject_q;
   assign err     = err_q;
   assign board_x = board_x_q;
   assign board_o = board_o_q;
   assign full    = full_q;
endmodule
